skolem_sweep_checker: RTL and testbench
=======================================

# skolem_sweep_checker

Sequential exhaustive checker placed directly downstream of the 4-bit `bvlshr`/`ne` Skolem-function netlists. It drives every 8-bit input vector into the combinational Skolem block and captures the 4-bit witness `x` it returns. For each vector it brute-forces all 16 candidate `x` to decide whether the constraint is satisfiable, then flags any vector where a witness exists but the Skolem output fails. Results are summarised as pass/fail, counters, and a first-failure capture.

## Interface
- `XPOS`, default 0: position of the unknown. 0 means constraint `(x >> s) != t`; 1 means `(s >> x) != t`.
- `SETTLE`, default 1, range 1..15: cycles the Skolem output is allowed to settle after `sk_in` changes.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low. One clock; reset is synchronous and active-low.
- `start` in 1: one-cycle request to begin a sweep.
- `sk_in` out 8: vector driven to the Skolem block, mapped to i0..i7. `s = sk_in[3:0]` (i0 is the LSB), `t = sk_in[7:4]`.
- `sk_x` in 4: Skolem witness from i8..i11, with i8 as the LSB.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes.
- `pass` out 1: 1 when `err_cnt == 0`. Valid from `done` until the next `start`.
- `err_cnt` out 9: count of failing vectors.
- `unsat_cnt` out 9: count of vectors with no satisfying `x`.
- `fail_valid` out 1: first-failure capture is loaded.
- `first_fail_vec` out 8: `sk_in` of the first failing vector.
- `first_fail_x` out 4: `sk_x` of the first failing vector.

## Operation
- **Reset values:** all outputs 0, state IDLE, vector register `vec` = 0x00.
- **State machine:** IDLE → WAIT → SEARCH → CHECK → (WAIT | DONE) → IDLE.
- **IDLE:**
  - `start` = 1: clear `err_cnt`, `unsat_cnt`, `fail_valid`, `first_fail_*`, and `pass`; set `vec` = 0; go to WAIT.
  - Otherwise hold all outputs.
- **WAIT:** `sk_in = vec`, held stable through WAIT, SEARCH and CHECK.
  - Count `SETTLE` cycles.
  - On the last WAIT cycle, register `sk_x` into `xw`.
  - Go to SEARCH with `cand` = 0 and `exists` = 0.
- **SEARCH:** 16 cycles, `cand` = 0..15.
  - Each cycle: `exists |= sat(cand)`.
  - `sat(c)` is `(c >> s) != t` for XPOS=0, or `(s >> c) != t` for XPOS=1.
  - Shifts are logical on 4 bits. Any shift amount ≥ 4 yields 0.
  - After `cand` = 15, go to CHECK.
- **CHECK:** one cycle.
  - If `exists` and `!sat(xw)`: increment `err_cnt`. If `fail_valid` = 0, load `first_fail_vec = vec`, `first_fail_x = xw`, and `fail_valid = 1`.
  - If `!exists`: increment `unsat_cnt`. No error is possible for that vector.
  - If `vec` = 0xFF: go to DONE. Otherwise `vec <= vec + 1` and go to WAIT.
- **DONE:** one cycle.
  - `done` = 1, `pass = (err_cnt == 0)`, `busy` = 0 on the next cycle.
  - Go to IDLE.
- **`busy`:** 1 in WAIT/SEARCH/CHECK/DONE, 0 in IDLE.
- **Counter widths:** 9 bits, max value 256, so no overflow and no saturation needed.
- **`start` while busy:** ignored. No restart and no counter change.
- **`start` in the DONE cycle:** ignored. A `start` in the following IDLE cycle is accepted.
- **Reset mid-sweep:** immediate return to reset values on the next edge. Partial results are discarded.

## Timing
- Per vector: `SETTLE + 17` cycles (WAIT `SETTLE` + SEARCH 16 + CHECK 1).
- Sweep: `start` accepted at edge E0. First WAIT cycle follows E0. `done` is high in cycle `E0 + 256·(SETTLE+17) + 1`.
- With SETTLE=1, `done` asserts 4609 cycles after the `start` edge.
- `sk_in` changes only on the CHECK→WAIT edge.
- `sk_x` is sampled exactly `SETTLE` cycles after `sk_in` changes.
- Counters update on the CHECK edge. `err_cnt`, `unsat_cnt` and `first_fail_*` are stable and readable while `done` = 1 and afterwards.

## Test plan
- **Correct model, XPOS=0, SETTLE=1:** bench computes a valid witness for each vector → `done` at cycle 4609; `pass` = 1, `err_cnt` = 0, `unsat_cnt` = 12 (t=0, s=4..15), `fail_valid` = 0.
- **`sk_x` tied to 0, XPOS=0:** → `err_cnt` = 4 (t=0, s=0..3), `unsat_cnt` = 12, `first_fail_vec` = 0x00, `first_fail_x` = 0, `pass` = 0.
- **`sk_x` tied to 0, XPOS=1:** → `err_cnt` = 15 (s=t≠0), `unsat_cnt` = 1 (vector 0x00), `first_fail_vec` = 0x11, `first_fail_x` = 0.
- **SETTLE=3:** Skolem model delays `x` by 3 cycles → `pass` = 1; `done` at cycle 256·20+1 = 5121. With the delay set to 4 instead, `err_cnt` > 0.
- **Control robustness:** `start` pulsed at cycle 100 mid-sweep → ignored, `done` timing unchanged. Assert `rst_n` = 0 for one edge at cycle 2000, then release → all outputs 0, state IDLE. A new `start` completes normally with the expected counts.

Source files
------------

// File: rtl/skolem_sweep_checker.sv
// Exhaustive sweep checker for a 4-bit bvlshr/ne Skolem witness block: drives all
// 256 (s,t) vectors, brute-forces satisfiability and counts vectors whose witness fails.
module skolem_sweep_checker #(
  parameter int XPOS   = 0,
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [7:0] sk_in,
  input  logic [3:0] sk_x,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt,
  output logic [8:0] unsat_cnt,
  output logic       fail_valid,
  output logic [7:0] first_fail_vec,
  output logic [3:0] first_fail_x
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SEARCH, S_CHECK, S_DONE} state_t;

  state_t     state;
  logic [7:0] vec;
  logic [3:0] settle_cnt;
  logic [3:0] cand;
  logic [3:0] xw;
  logic       exists;
  logic       fail_now;

  // Constraint for candidate c against vector v = {t, s}; 4-bit logical shifts
  // by 4 or more naturally produce 0.
  function automatic logic sat(input logic [3:0] c, input logic [7:0] v);
    logic [3:0] s;
    logic [3:0] t;
    s = v[3:0];
    t = v[7:4];
    if (XPOS == 0) return (c >> s) != t;
    else           return (s >> c) != t;
  endfunction

  assign sk_in    = vec;
  assign fail_now = exists && !sat(xw, vec);

  // NOTE: all state updates use non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it is just the highest-priority branch here.
    if (!rst_n) begin
      state          <= S_IDLE;
      vec            <= 8'h00;
      settle_cnt     <= 4'd0;
      cand           <= 4'd0;
      xw             <= 4'd0;
      exists         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= 9'd0;
      unsat_cnt      <= 9'd0;
      fail_valid     <= 1'b0;
      first_fail_vec <= 8'h00;
      first_fail_x   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err_cnt        <= 9'd0;
            unsat_cnt      <= 9'd0;
            fail_valid     <= 1'b0;
            first_fail_vec <= 8'h00;
            first_fail_x   <= 4'd0;
            pass           <= 1'b0;
            vec            <= 8'h00;
            settle_cnt     <= 4'd0;
            busy           <= 1'b1;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (settle_cnt == 4'(SETTLE - 1)) begin
            xw         <= sk_x;
            settle_cnt <= 4'd0;
            cand       <= 4'd0;
            exists     <= 1'b0;
            state      <= S_SEARCH;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_SEARCH: begin
          exists <= exists | sat(cand, vec);
          cand   <= cand + 4'd1;
          if (cand == 4'd15) state <= S_CHECK;
        end
        S_CHECK: begin
          if (fail_now) begin
            err_cnt <= err_cnt + 9'd1;
            if (!fail_valid) begin
              fail_valid     <= 1'b1;
              first_fail_vec <= vec;
              first_fail_x   <= xw;
            end
          end
          if (!exists) unsat_cnt <= unsat_cnt + 9'd1;
          if (vec == 8'hFF) begin
            // The last vector's verdict is folded in here so pass is valid with done.
            done  <= 1'b1;
            pass  <= (err_cnt == 9'd0) && !fail_now;
            state <= S_DONE;
          end else begin
            vec   <= vec + 8'd1;
            state <= S_WAIT;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Directed bench for skolem_sweep_checker: three instances (XPOS/SETTLE variants)
// fed by behavioural Skolem models; each scenario task checks its own results.
module tb_skolem_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Scenario steering: sel picks the instance, start_req is routed to it.
  int   sel = 0;
  logic start_req = 1'b0;
  logic tie0 = 1'b0;   // instance 0: 1 = sk_x tied to 0, 0 = correct witness
  int   dly3 = 3;      // instance 2: model latency in cycles (3 or 4)

  logic       start0, start1, start3;
  logic [7:0] sk_in0, sk_in1, sk_in3;
  logic [3:0] sk_x0, sk_x1, sk_x3;
  logic       busy0, busy1, busy3, done0, done1, done3, pass0, pass1, pass3;
  logic [8:0] err0, err1, err3, unsat0, unsat1, unsat3;
  logic       fv0, fv1, fv3;
  logic [7:0] ffv0, ffv1, ffv3;
  logic [3:0] ffx0, ffx1, ffx3;
  logic [7:0] pipe [3];

  // Valid witness for XPOS=0: t!=0 -> x=0 gives 0 != t; t=0,s<4 -> x=1<<s gives 1.
  function automatic logic [3:0] wit(input logic [7:0] v);
    if (v[7:4] == 4'd0 && v[3:0] < 4'd4) return 4'd1 << v[1:0];
    return 4'd0;
  endfunction

  // Registered model path: latency D means D-1 register stages after sk_in.
  always @(posedge clk) begin
    pipe[0] <= sk_in3;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  assign start0 = start_req && (sel == 0);
  assign start1 = start_req && (sel == 1);
  assign start3 = start_req && (sel == 2);
  assign sk_x0  = tie0 ? 4'd0 : wit(sk_in0);
  assign sk_x1  = 4'd0;
  assign sk_x3  = (dly3 == 3) ? wit(pipe[1]) : wit(pipe[2]);

  skolem_sweep_checker #(.XPOS(0), .SETTLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sk_in(sk_in0), .sk_x(sk_x0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .unsat_cnt(unsat0),
    .fail_valid(fv0), .first_fail_vec(ffv0), .first_fail_x(ffx0));

  skolem_sweep_checker #(.XPOS(1), .SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .sk_in(sk_in1), .sk_x(sk_x1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .unsat_cnt(unsat1),
    .fail_valid(fv1), .first_fail_vec(ffv1), .first_fail_x(ffx1));

  skolem_sweep_checker #(.XPOS(0), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .sk_in(sk_in3), .sk_x(sk_x3),
    .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3), .unsat_cnt(unsat3),
    .fail_valid(fv3), .first_fail_vec(ffv3), .first_fail_x(ffx3));

  logic       busy_m, done_m, pass_m, fv_m;
  logic [8:0] err_m, unsat_m;
  logic [7:0] ffv_m, sk_in_m;
  logic [3:0] ffx_m;

  always_comb begin
    busy_m = busy0; done_m = done0; pass_m = pass0; fv_m = fv0;
    err_m = err0; unsat_m = unsat0; ffv_m = ffv0; ffx_m = ffx0; sk_in_m = sk_in0;
    if (sel == 1) begin
      busy_m = busy1; done_m = done1; pass_m = pass1; fv_m = fv1;
      err_m = err1; unsat_m = unsat1; ffv_m = ffv1; ffx_m = ffx1; sk_in_m = sk_in1;
    end else if (sel == 2) begin
      busy_m = busy3; done_m = done3; pass_m = pass3; fv_m = fv3;
      err_m = err3; unsat_m = unsat3; ffv_m = ffv3; ffx_m = ffx3; sk_in_m = sk_in3;
    end
  end

  // Start a sweep on the selected instance and wait (bounded) for done.
  // edges counts rising edges after the start-accepting edge E0; done in cycle
  // E0+N+1 is seen after edge E0+N.  sk_a/sk_b are sk_in after edges per_vec-1
  // and per_vec, straddling the first CHECK->WAIT transition.
  task automatic run_sweep(input int poke_at, input int per_vec, output int edges,
                           output logic busy_first, output logic [7:0] sk_a,
                           output logic [7:0] sk_b);
    @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    start_req  = 1'b0;
    busy_first = busy_m;
    edges = 0;
    sk_a = 8'hxx;
    sk_b = 8'hxx;
    while (!done_m && edges < 6000) begin
      start_req = (edges == poke_at);
      @(negedge clk);
      edges++;
      if (edges == per_vec - 1) sk_a = sk_in_m;
      if (edges == per_vec)     sk_b = sk_in_m;
    end
    start_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] st [3];
    st[0] = {busy0, done0, pass0, fv0, err0, unsat0, ffv0, ffx0, sk_in0};
    st[1] = {busy1, done1, pass1, fv1, err1, unsat1, ffv1, ffx1, sk_in1};
    st[2] = {busy3, done3, pass3, fv3, err3, unsat3, ffv3, ffx3, sk_in3};
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (st[i] !== 38'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d: got %h expected 0", i, st[i]);
      end
    end
  endtask

  task automatic test_correct_x0();
    int edges; logic bf; logic [7:0] a, b;
    sel = 0; tie0 = 1'b0;
    // A start pulse mid-sweep at cycle 100 must be ignored.
    run_sweep(100, 18, edges, bf, a, b);
    checks++; if (bf !== 1'b1) begin failures++; $display("FAIL correct_busy_after_start: got %b expected 1", bf); end
    checks++; if (edges != 4608) begin failures++; $display("FAIL correct_done_timing: got %0d expected 4608", edges); end
    checks++; if (a !== 8'h00 || b !== 8'h01) begin failures++; $display("FAIL correct_vec_step: got %h,%h expected 00,01", a, b); end
    checks++; if (pass_m !== 1'b1) begin failures++; $display("FAIL correct_pass: got %b expected 1", pass_m); end
    checks++; if (err_m !== 9'd0) begin failures++; $display("FAIL correct_err_cnt: got %0d expected 0", err_m); end
    checks++; if (unsat_m !== 9'd12) begin failures++; $display("FAIL correct_unsat_cnt: got %0d expected 12", unsat_m); end
    checks++; if (fv_m !== 1'b0) begin failures++; $display("FAIL correct_fail_valid: got %b expected 0", fv_m); end
  endtask

  // Entered in the DONE cycle of the previous sweep.
  task automatic test_start_in_done();
    start_req = 1'b1;
    @(negedge clk);
    start_req = 1'b0;
    checks++; if (busy_m !== 1'b0 || done_m !== 1'b0) begin failures++; $display("FAIL done_start_ignored: busy=%b done=%b expected 0,0", busy_m, done_m); end
    @(negedge clk);
    checks++; if (busy_m !== 1'b0 || pass_m !== 1'b1 || unsat_m !== 9'd12) begin
      failures++; $display("FAIL idle_hold: busy=%b pass=%b unsat=%0d expected 0,1,12", busy_m, pass_m, unsat_m);
    end
  endtask

  task automatic test_reset_mid();
    int edges; logic bf; logic [7:0] a, b;
    sel = 0; tie0 = 1'b0;
    @(negedge clk); start_req = 1'b1;
    @(negedge clk); start_req = 1'b0;
    for (int i = 1; i < 2000; i++) @(negedge clk);
    checks++; if (busy_m !== 1'b1 || unsat_m !== 9'd12) begin failures++; $display("FAIL mid_sweep_state: busy=%b unsat=%0d expected 1,12", busy_m, unsat_m); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({busy0, done0, pass0, fv0, err0, unsat0, ffv0, ffx0, sk_in0} !== 38'd0) begin
      failures++; $display("FAIL mid_reset_outputs: busy=%b unsat=%0d sk_in=%h expected all 0", busy0, unsat0, sk_in0);
    end
    repeat (3) @(negedge clk);
    checks++; if (busy_m !== 1'b0 || sk_in_m !== 8'h00) begin failures++; $display("FAIL mid_reset_idle: busy=%b sk_in=%h expected 0,00", busy_m, sk_in_m); end
    run_sweep(-1, 18, edges, bf, a, b);
    checks++; if (edges != 4608 || pass_m !== 1'b1 || err_m !== 9'd0 || unsat_m !== 9'd12) begin
      failures++; $display("FAIL rerun_after_reset: edges=%0d pass=%b err=%0d unsat=%0d expected 4608,1,0,12", edges, pass_m, err_m, unsat_m);
    end
  endtask

  task automatic test_tied0_x0();
    int edges; logic bf; logic [7:0] a, b;
    sel = 0; tie0 = 1'b1;
    run_sweep(-1, 18, edges, bf, a, b);
    checks++; if (edges != 4608) begin failures++; $display("FAIL tie0_x0_timing: got %0d expected 4608", edges); end
    checks++; if (err_m !== 9'd4 || unsat_m !== 9'd12) begin failures++; $display("FAIL tie0_x0_counts: err=%0d unsat=%0d expected 4,12", err_m, unsat_m); end
    checks++; if (fv_m !== 1'b1 || ffv_m !== 8'h00 || ffx_m !== 4'd0 || pass_m !== 1'b0) begin
      failures++; $display("FAIL tie0_x0_capture: fv=%b vec=%h x=%h pass=%b expected 1,00,0,0", fv_m, ffv_m, ffx_m, pass_m);
    end
    tie0 = 1'b0;
  endtask

  task automatic test_tied0_x1();
    int edges; logic bf; logic [7:0] a, b;
    sel = 1;
    run_sweep(-1, 18, edges, bf, a, b);
    checks++; if (err_m !== 9'd15 || unsat_m !== 9'd1) begin failures++; $display("FAIL tie0_x1_counts: err=%0d unsat=%0d expected 15,1", err_m, unsat_m); end
    checks++; if (fv_m !== 1'b1 || ffv_m !== 8'h11 || ffx_m !== 4'd0 || pass_m !== 1'b0) begin
      failures++; $display("FAIL tie0_x1_capture: fv=%b vec=%h x=%h pass=%b expected 1,11,0,0", fv_m, ffv_m, ffx_m, pass_m);
    end
  endtask

  task automatic test_settle3();
    int edges; logic bf; logic [7:0] a, b;
    sel = 2; dly3 = 3;
    run_sweep(-1, 20, edges, bf, a, b);
    checks++; if (edges != 5120) begin failures++; $display("FAIL settle3_timing: got %0d expected 5120", edges); end
    checks++; if (a !== 8'h00 || b !== 8'h01) begin failures++; $display("FAIL settle3_vec_step: got %h,%h expected 00,01", a, b); end
    checks++; if (pass_m !== 1'b1 || err_m !== 9'd0 || unsat_m !== 9'd12) begin
      failures++; $display("FAIL settle3_result: pass=%b err=%0d unsat=%0d expected 1,0,12", pass_m, err_m, unsat_m);
    end
  endtask

  // Latency 4 samples the previous vector's witness; previous sweep left sk_in=FF,
  // so vectors 00..03 (t=0, s<4) all get a stale x that fails.
  task automatic test_settle3_delay4();
    int edges; logic bf; logic [7:0] a, b;
    sel = 2; dly3 = 4;
    run_sweep(-1, 20, edges, bf, a, b);
    checks++; if (err_m !== 9'd4 || pass_m !== 1'b0 || unsat_m !== 9'd12) begin
      failures++; $display("FAIL delay4_result: err=%0d pass=%b unsat=%0d expected 4,0,12", err_m, pass_m, unsat_m);
    end
    checks++; if (fv_m !== 1'b1 || ffv_m !== 8'h00 || ffx_m !== 4'd0) begin
      failures++; $display("FAIL delay4_capture: fv=%b vec=%h x=%h expected 1,00,0", fv_m, ffv_m, ffx_m);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_correct_x0();
    test_start_in_done();
    test_reset_mid();
    test_tied0_x0();
    test_tied0_x1();
    test_settle3();
    test_settle3_delay4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
